// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing the UDP TX application port among NUM_CLI packet sources:
// request/ack handshake, length-exact byte streaming and an inter-packet gap.
module udp_tx_arbiter #(
    parameter int unsigned NUM_CLI     = 3,
    parameter int unsigned GAP_CYCLES  = 10000,
    parameter int unsigned ACK_TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLI-1:0]     cli_req,
    input  logic [16*NUM_CLI-1:0]  cli_len,
    input  logic [8*NUM_CLI-1:0]   cli_data,
    output logic [NUM_CLI-1:0]     cli_grant,
    output logic [NUM_CLI-1:0]     cli_rd,
    output logic [NUM_CLI-1:0]     cli_done,
    output logic                   cli_err,
    input  logic                   udp_tx_ready,
    input  logic                   app_tx_ack,
    output logic                   app_tx_data_request,
    output logic                   app_tx_data_valid,
    output logic [7:0]             app_tx_data,
    output logic [15:0]            udp_data_length
);
    localparam int unsigned IdxW = (NUM_CLI > 1) ? $clog2(NUM_CLI) : 1;
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned AckW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AckW-1:0] AckLast = AckW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {StIdle, StWaitReady, StWaitAck, StStream, StGap} state_e;

    state_e             state_q, state_d;
    logic [NUM_CLI-1:0] grant_q, grant_d;
    logic [NUM_CLI-1:0] done_q, done_d;
    logic [IdxW-1:0]    gidx_q, gidx_d;
    logic [IdxW-1:0]    last_q, last_d;
    logic [IdxW-1:0]    pick_idx;
    logic               err_q, err_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         cur_data;
    logic [15:0]        len_q, len_d;
    logic [15:0]        pick_len;
    logic [15:0]        byte_cnt_q, byte_cnt_d;
    logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [AckW-1:0]    ack_cnt_q, ack_cnt_d;

    // Scan from farthest to nearest so the first requester after 'last' wins.
    function automatic logic [IdxW-1:0] rr_next(input logic [NUM_CLI-1:0] req,
                                                input logic [IdxW-1:0]    last);
        logic [IdxW-1:0] sel;
        int unsigned     c;
        sel = last;
        for (int unsigned k = NUM_CLI; k > 0; k--) begin
            c = (32'(last) + k) % NUM_CLI;
            if (req[c[IdxW-1:0]]) sel = c[IdxW-1:0];
        end
        return sel;
    endfunction

    assign pick_idx = rr_next(cli_req, last_q);
    assign pick_len = cli_len[{pick_idx, 4'b0000} +: 16];
    assign cur_data = cli_data[{gidx_q, 3'b000} +: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            done_q     <= '0;
            gidx_q     <= '0;
            last_q     <= IdxW'(NUM_CLI - 1);
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ack_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            gidx_q     <= gidx_d;
            last_q     <= last_d;
            err_q      <= err_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ack_cnt_q  <= ack_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = '0;
        gidx_d     = gidx_q;
        last_d     = last_q;
        err_d      = 1'b0;
        req_d      = req_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ack_cnt_d  = ack_cnt_q;
        cli_rd     = '0;

        unique case (state_q)
            StIdle: begin
                if (|cli_req) begin
                    gidx_d  = pick_idx;
                    last_d  = pick_idx;
                    len_d   = pick_len;
                    grant_d = '0;
                    grant_d[pick_idx] = 1'b1;
                    if (pick_len == 16'd0) begin
                        done_d    = grant_d;
                        gap_cnt_d = '0;
                        state_d   = StGap;
                    end else begin
                        state_d = StWaitReady;
                    end
                end
            end
            StWaitReady: begin
                if (udp_tx_ready) begin
                    req_d     = 1'b1;
                    ack_cnt_d = '0;
                    state_d   = StWaitAck;
                end
            end
            StWaitAck: begin
                if (app_tx_ack) begin
                    req_d      = 1'b0;
                    byte_cnt_d = '0;
                    state_d    = StStream;
                end else if (ack_cnt_q == AckLast) begin
                    req_d     = 1'b0;
                    done_d    = grant_q;
                    err_d     = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            StStream: begin
                if (byte_cnt_q < len_q) begin
                    cli_rd     = grant_q;
                    valid_d    = 1'b1;
                    data_d     = cur_data;
                    byte_cnt_d = byte_cnt_q + 16'd1;
                end else begin
                    done_d    = grant_q;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end
            end
            StGap: begin
                // The first gap cycle is the cli_done cycle; grant drops with it.
                grant_d = '0;
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cli_grant           = grant_q;
    assign cli_done            = done_q;
    assign cli_err             = err_q;
    assign app_tx_data_request = req_q;
    assign app_tx_data_valid   = valid_q;
    assign app_tx_data         = data_q;
    assign udp_data_length     = len_q;

endmodule
